// File: rtl/spi_cmd_slave.sv
// SPI slave command front-end for the NPU.
// Oversamples sclk/mosi/cs_n in the clk domain, decodes CMD/ADDR/DATA frames
// into register write/read strobes, start pulses and status readback on miso.
module spi_cmd_slave #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              npu_busy,
  input  logic              npu_done,
  output logic              start,
  output logic              frame_err
);

  localparam int F  = 8 + ADDR_W + DATA_W;
  localparam int CW = $clog2(F + 1);
  localparam int TW = ADDR_W + DATA_W;

  localparam logic [CW-1:0] N_CMD  = CW'(7);
  localparam logic [CW-1:0] N_ADDR = CW'(8 + ADDR_W - 1);
  localparam logic [CW-1:0] N_LAST = CW'(F - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [7:0] C_WR    = 8'h01;
  localparam logic [7:0] C_START = 8'h02;
  localparam logic [7:0] C_RD    = 8'h03;
  localparam logic [7:0] C_STAT  = 8'h04;

  // [0],[1] synchronise, [2] is the previous value for edge detect
  logic [2:0] sclk_q, mosi_q, cs_q;

  logic          cs_s, cs_fall, cs_rise;
  logic          sclk_rise, sclk_fall, lead_e, trail_e, samp_e, shift_e;
  logic          mosi_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [F-1:0]  rx, rx_nxt;
  logic [7:0]    cmd;
  logic          tx_en, stat_ld, rd_q, tx_phase;
  logic [TW-1:0] tx;

  // Pin synchronisers; cleared to 0 so a frame in flight at reset release
  // never produces a fake cs_n falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      mosi_q <= '0;
      cs_q   <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[1:0], mosi};
      cs_q   <= {cs_q[1:0], cs_n};
    end
  end

  // mosi taken from the third stage so it lines up with the edge being seen
  assign mosi_s    = mosi_q[2];
  assign cs_s      = cs_q[1];
  assign cs_fall   = ~cs_q[1] &  cs_q[2];
  assign cs_rise   =  cs_q[1] & ~cs_q[2];
  assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
  assign lead_e    = CPOL ? sclk_fall : sclk_rise;
  assign trail_e   = CPOL ? sclk_rise : sclk_fall;
  assign samp_e    = (CPHA ? trail_e : lead_e) & ~cs_s;
  assign shift_e   = (CPHA ? lead_e : trail_e) & ~cs_s;
  assign rx_nxt    = {rx[F-2:0], mosi_s};
  assign tx_phase  = (state == S_ADDR) || (state == S_DATA);

  // Frame FSM: bit counting, command decode and the one-cycle strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rx        <= '0;
      cmd       <= '0;
      tx_en     <= 1'b0;
      stat_ld   <= 1'b0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      start     <= 1'b0;
      frame_err <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      start     <= 1'b0;
      frame_err <= 1'b0;
      stat_ld   <= 1'b0;
      if (state != S_IDLE && cs_rise) begin
        // deselect before the last bit aborts the frame; a WRITE is dropped
        if (state != S_DONE) frame_err <= 1'b1;
        state <= S_IDLE;
        tx_en <= 1'b0;
      end else if (state == S_IDLE) begin
        if (cs_fall) begin
          state <= S_CMD;
          cnt   <= '0;
          rx    <= '0;
          cmd   <= '0;
          tx_en <= 1'b0;
        end
      end else if (samp_e && state != S_DONE) begin
        rx  <= rx_nxt;
        cnt <= cnt + CW'(1);
        case (state)
          S_CMD: if (cnt == N_CMD) begin
            cmd <= rx_nxt[7:0];
            case (rx_nxt[7:0])
              C_WR:    state <= S_ADDR;
              C_RD:    begin state <= S_ADDR; tx_en <= 1'b1; end
              C_STAT:  begin state <= S_ADDR; tx_en <= 1'b1; stat_ld <= 1'b1; end
              C_START: begin state <= S_DONE; start <= 1'b1; end
              default: begin state <= S_DONE; frame_err <= 1'b1; end
            endcase
          end
          S_ADDR: if (cnt == N_ADDR) begin
            state <= S_DATA;
            if (cmd == C_RD) begin
              reg_rd_en <= 1'b1;
              reg_addr  <= rx_nxt[ADDR_W-1:0];
            end
          end
          S_DATA: if (cnt == N_LAST) begin
            state <= S_DONE;
            if (cmd == C_WR) begin
              reg_wr_en <= 1'b1;
              reg_addr  <= rx_nxt[DATA_W +: ADDR_W];
              reg_wdata <= rx_nxt[DATA_W-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // TX shifter spans ADDR+DATA; the ADDR part is zero so those bits shift out 0.
  // READ data lands in the top DATA_W bits because the ADDR shifts are already done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx   <= '0;
      miso <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      rd_q <= reg_rd_en;
      if (stat_ld)
        tx <= TW'({npu_busy, npu_done});
      else if (rd_q)
        tx <= {reg_rdata, {ADDR_W{1'b0}}};
      else if (shift_e && tx_phase)
        tx <= {tx[TW-2:0], 1'b0};
      if (cs_s || !tx_en || state == S_DONE)
        miso <= 1'b0;
      else if (shift_e)
        miso <= tx_phase ? tx[TW-1] : 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Bench for spi_cmd_slave: three instances (mode 0 default widths, mode 3
// default widths, CPOL=1/CPHA=0 with ADDR_W=4/DATA_W=32) share sclk/mosi and
// have their own cs_n. Expected events go into a scoreboard queue; a monitor
// pops and compares whenever a DUT strobes or a MISO word is collected.
module tb_spi_cmd_slave;

  localparam int HP = 5;
  localparam int K_WR = 0, K_RD = 1, K_START = 2, K_ERR = 3, K_MISO = 4;

  typedef struct {
    int          dut;
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  failures = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, mosi, busy, done;
  logic [2:0]  cs_n, miso, wr_en, rd_en, st, ferr;
  logic [7:0]  addr0, addr1;
  logic [3:0]  addr2;
  logic [15:0] wd0, wd1, rdd0, rdd1;
  logic [31:0] wd2, rdd2;

  logic        miso_vld;
  int          miso_dut;
  logic [31:0] miso_word;

  int fw[3]     = '{32, 32, 44};
  int dw[3]     = '{16, 16, 32};
  bit cpol_c[3] = '{1'b0, 1'b1, 1'b1};
  bit cpha_c[3] = '{1'b0, 1'b1, 1'b0};

  always #10 clk = ~clk;

  spi_cmd_slave #(.ADDR_W(8), .DATA_W(16), .CPOL(1'b0), .CPHA(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n[0]), .miso(miso[0]),
    .reg_wr_en(wr_en[0]), .reg_rd_en(rd_en[0]), .reg_addr(addr0), .reg_wdata(wd0),
    .reg_rdata(rdd0), .npu_busy(busy), .npu_done(done), .start(st[0]), .frame_err(ferr[0]));

  spi_cmd_slave #(.ADDR_W(8), .DATA_W(16), .CPOL(1'b1), .CPHA(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n[1]), .miso(miso[1]),
    .reg_wr_en(wr_en[1]), .reg_rd_en(rd_en[1]), .reg_addr(addr1), .reg_wdata(wd1),
    .reg_rdata(rdd1), .npu_busy(busy), .npu_done(done), .start(st[1]), .frame_err(ferr[1]));

  spi_cmd_slave #(.ADDR_W(4), .DATA_W(32), .CPOL(1'b1), .CPHA(1'b0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n[2]), .miso(miso[2]),
    .reg_wr_en(wr_en[2]), .reg_rd_en(rd_en[2]), .reg_addr(addr2), .reg_wdata(wd2),
    .reg_rdata(rdd2), .npu_busy(busy), .npu_done(done), .start(st[2]), .frame_err(ferr[2]));

  // Register file model: data valid exactly one clk after the read strobe
  always @(posedge clk) begin
    rdd0 <= rd_en[0] ? ((addr0 == 8'h05) ? 16'hA5C3 : 16'h0BAD) : 16'h0000;
    rdd1 <= rd_en[1] ? ((addr1 == 8'h05) ? 16'hA5C3 : 16'h0BAD) : 16'h0000;
    rdd2 <= rd_en[2] ? ((addr2 == 4'h5) ? 32'h1234A5C3 : 32'h0BAD0BAD) : 32'h0;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int d, input int k, input logic [31:0] a, input logic [31:0] v);
    ev_t e;
    e.dut = d; e.kind = k; e.addr = a; e.data = v;
    sb.push_back(e);
  endtask

  task automatic obs(input int d, input int k, input logic [31:0] a, input logic [31:0] v);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got dut%0d kind=%0d addr=%h data=%h, none expected", d, k, a, v);
    end else begin
      e = sb.pop_front();
      if (e.dut != d || e.kind != k || e.addr !== a || e.data !== v) begin
        failures++;
        $display("FAIL event: got dut%0d kind=%0d addr=%h data=%h, want dut%0d kind=%0d addr=%h data=%h",
                 d, k, a, v, e.dut, e.kind, e.addr, e.data);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if ({miso, wr_en, rd_en, st, ferr} !== 15'h0) begin
      failures++;
      $display("FAIL %s_strobes: got %h want 0", tag, {miso, wr_en, rd_en, st, ferr});
    end
    checks++;
    if ({addr0, addr1, addr2, wd0, wd1, wd2} !== 100'h0) begin
      failures++;
      $display("FAIL %s_buses: got %h want 0", tag, {addr0, addr1, addr2, wd0, wd1, wd2});
    end
  endtask

  // Drives one frame MSB first; abort_rst pulls reset low after nsend bits
  task automatic spi_frame(input int d, input logic [63:0] frm, input int nsend,
                           input bit abort_rst, output logic [63:0] got);
    int f;
    f = fw[d];
    got = '0;
    sclk = cpol_c[d];
    mosi = 1'b0;
    wait_clk(4);
    cs_n[d] = 1'b0;
    if (!cpha_c[d]) mosi = frm[f-1];
    wait_clk(HP);
    for (int i = 0; i < nsend; i++) begin
      if (!cpha_c[d]) begin
        got = {got[62:0], miso[d]};
        sclk = ~sclk;
        wait_clk(HP);
        sclk = ~sclk;
        if (i < nsend - 1) mosi = frm[f-2-i];
        wait_clk(HP);
      end else begin
        sclk = ~sclk;
        mosi = frm[f-1-i];
        wait_clk(HP);
        got = {got[62:0], miso[d]};
        sclk = ~sclk;
        wait_clk(HP);
      end
    end
    if (abort_rst) begin
      rst_n = 1'b0;
      wait_clk(2);
      check_idle("midframe_reset");
      rst_n = 1'b1;
      wait_clk(2);
    end
    cs_n[d] = 1'b1;
    mosi = 1'b0;
    wait_clk(6);
  endtask

  task automatic run(input int d, input logic [63:0] frm, input int nsend,
                     input bit abort_rst, input bit chk_miso);
    logic [63:0] got;
    spi_frame(d, frm, nsend, abort_rst, got);
    if (chk_miso) begin
      miso_word = (dw[d] == 32) ? got[31:0] : {16'h0, got[15:0]};
      miso_dut  = d;
      miso_vld  = 1'b1;
      wait_clk(1);
      miso_vld  = 1'b0;
      wait_clk(1);
    end
  endtask

  // Monitor: every strobe or collected MISO word is checked against the queue
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int d = 0; d < 3; d++) begin
          int n;
          logic [31:0] a, w;
          n = int'(wr_en[d]) + int'(rd_en[d]) + int'(st[d]) + int'(ferr[d]);
          a = (d == 0) ? {24'h0, addr0} : (d == 1) ? {24'h0, addr1} : {28'h0, addr2};
          w = (d == 0) ? {16'h0, wd0} : (d == 1) ? {16'h0, wd1} : wd2;
          if (n > 0) begin
            checks++;
            if (n > 1) begin
              failures++;
              $display("FAIL strobe_onehot dut%0d: got %0d strobes want 1", d, n);
            end
          end
          if (wr_en[d]) obs(d, K_WR, a, w);
          if (rd_en[d]) obs(d, K_RD, a, 32'h0);
          if (st[d])    obs(d, K_START, 32'h0, 32'h0);
          if (ferr[d])  obs(d, K_ERR, 32'h0, 32'h0);
        end
        if (miso_vld) obs(miso_dut, K_MISO, 32'h0, miso_word);
      end
    end
  end

  initial begin
    rst_n = 1'b0; cs_n = 3'b111; sclk = 1'b0; mosi = 1'b0;
    busy = 1'b0; done = 1'b0;
    miso_vld = 1'b0; miso_dut = 0; miso_word = '0;
    wait_clk(3);
    check_idle("reset");
    rst_n = 1'b1;
    wait_clk(4);

    // mode 0, default widths
    expect_ev(0, K_WR, 32'h12, 32'hBEEF);
    run(0, 64'h0112BEEF, 32, 1'b0, 1'b0);
    expect_ev(0, K_START, 32'h0, 32'h0);
    run(0, 64'h02000000, 32, 1'b0, 1'b0);
    expect_ev(0, K_RD, 32'h05, 32'h0);
    expect_ev(0, K_MISO, 32'h0, 32'hA5C3);
    run(0, 64'h03050000, 32, 1'b0, 1'b1);
    busy = 1'b1; done = 1'b0;
    expect_ev(0, K_MISO, 32'h0, 32'h0002);
    run(0, 64'h04000000, 32, 1'b0, 1'b1);
    busy = 1'b0; done = 1'b1;
    expect_ev(0, K_MISO, 32'h0, 32'h0001);
    run(0, 64'h04000000, 32, 1'b0, 1'b1);
    // deselect after 20 bits of WRITE, then a clean frame
    expect_ev(0, K_ERR, 32'h0, 32'h0);
    run(0, 64'h01345678, 20, 1'b0, 1'b0);
    expect_ev(0, K_WR, 32'h56, 32'h1357);
    run(0, 64'h01561357, 32, 1'b0, 1'b0);
    // illegal command; the tail of the frame must be ignored
    expect_ev(0, K_ERR, 32'h0, 32'h0);
    run(0, 64'h7E01FFFF, 32, 1'b0, 1'b0);

    // CPOL=1, CPHA=1
    expect_ev(1, K_WR, 32'h12, 32'hBEEF);
    run(1, 64'h0112BEEF, 32, 1'b0, 1'b0);
    expect_ev(1, K_RD, 32'h05, 32'h0);
    expect_ev(1, K_MISO, 32'h0, 32'hA5C3);
    run(1, 64'h03050000, 32, 1'b0, 1'b1);

    // ADDR_W=4, DATA_W=32, CPOL=1, CPHA=0
    expect_ev(2, K_WR, 32'h2, 32'hCAFEBEEF);
    run(2, {8'h01, 4'h2, 32'hCAFEBEEF}, 44, 1'b0, 1'b0);
    expect_ev(2, K_RD, 32'h5, 32'h0);
    expect_ev(2, K_MISO, 32'h0, 32'h1234A5C3);
    run(2, {8'h03, 4'h5, 32'h0}, 44, 1'b0, 1'b1);
    busy = 1'b1; done = 1'b1;
    expect_ev(2, K_MISO, 32'h0, 32'h00000003);
    run(2, {8'h04, 4'h0, 32'h0}, 44, 1'b0, 1'b1);
    busy = 1'b0; done = 1'b0;

    // reset in the middle of a WRITE: nothing issued, next frame decodes
    run(0, 64'h01ABCDEF, 20, 1'b1, 1'b0);
    expect_ev(0, K_WR, 32'h9A, 32'h4321);
    run(0, 64'h019A4321, 32, 1'b0, 1'b0);

    wait_clk(10);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cmd_slave.md
Name: spi_cmd_slave

Overview:
- SPI slave command front-end for the NPU. Oversamples the SPI pins in the `clk` domain and decodes framed commands into NPU control actions: register writes, register reads, start pulses and status reads.
- Successor to the fixed 24-bit start-only SPI decode. Frame widths and SPI mode are parametrised, and MISO readback is added.
- Sits between the top-level SPI pins and the NPU register file/controller.

Parameters:
- ADDR_W, 8, register address field width (bits); 1..16.
- DATA_W, 16, register data field width (bits); 8..32.
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading edge / sample on trailing edge.

Ports:
- clk  in  1  system clock (27 MHz nominal).
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock, asynchronous to clk.
- mosi  in  1  SPI data in, MSB first.
- cs_n  in  1  SPI chip select, active low.
- miso  out  1  SPI data out, MSB first.
- reg_wr_en  out  1  one-cycle register write strobe.
- reg_rd_en  out  1  one-cycle register read strobe.
- reg_addr  out  ADDR_W  register address, valid with either strobe.
- reg_wdata  out  DATA_W  write data, valid with reg_wr_en.
- reg_rdata  in  DATA_W  read data, valid exactly 1 clk after reg_rd_en.
- npu_busy  in  1  NPU busy status.
- npu_done  in  1  NPU done status.
- start  out  1  one-cycle NPU start pulse.
- frame_err  out  1  one-cycle pulse on an aborted or illegal frame.

Behaviour:
- Reset: all outputs 0, miso 0, FSM in IDLE, shift registers cleared. Reset takes effect mid-frame with no pending strobe issued.
- Synchronisation: sclk, mosi and cs_n each pass through a 2-FF synchroniser plus a third register for edge detect.
  - Supported rate: SCLK half-period ≥ 4 clk cycles.
  - Edges are derived from the synchronised sclk, qualified by CPOL/CPHA.
  - Edges are ignored while synchronised cs_n = 1.
- Frame layout, MSB first: CMD[7:0], ADDR[ADDR_W-1:0], DATA[DATA_W-1:0]. Total F = 8 + ADDR_W + DATA_W sample edges; the default is 32.
- Commands:
  - 0x01 WRITE: reg_wr_en pulses 1 clk after the F-th sample edge. reg_addr/reg_wdata come from the frame.
  - 0x02 START: start pulses 1 clk after the 8th sample edge. Remaining bits are ignored.
  - 0x03 READ: reg_rd_en pulses 1 clk after the (8+ADDR_W)-th sample edge. reg_rdata is captured the next clk into the TX shifter and driven on miso during the DATA phase.
  - 0x04 STATUS: the TX shifter loads {DATA_W-2 zeros, npu_busy, npu_done} 1 clk after the 8th sample edge. It is shifted out through the ADDR and DATA phases; ADDR bits shift out 0.
  - Any other CMD: frame_err pulses 1 clk after the 8th sample edge and the rest of the frame is ignored.
- FSM states and transitions:
  - IDLE → CMD on the cs_n falling edge.
  - CMD → ADDR after 8 bits.
  - ADDR → DATA after ADDR_W bits.
  - DATA → DONE after DATA_W bits.
  - DONE → IDLE on cs_n rising edge.
  - START and illegal commands go CMD → DONE directly.
- TX timing:
  - CPHA=0: the first DATA bit is presented on miso before the first DATA-phase sample edge, i.e. loaded at the last ADDR-phase shift edge.
  - CPHA=1: the first DATA bit is shifted out on the leading edge.
  - miso is 0 outside READ/STATUS data phases and while cs_n = 1.
- Boundary conditions:
  - cs_n rising before F bits in WRITE/READ: frame_err pulses 1 clk after the synchronised rise. No reg_wr_en is issued; a reg_rd_en already issued stands.
  - Extra edges after F bits: ignored; the FSM stays in DONE.
  - cs_n rising and falling within 1 clk: treated as separate frames only if both are seen post-synchroniser.
  - Bit counter: sized to F; it never wraps within a frame.
- Strobes: at most one of reg_wr_en, reg_rd_en, start is high in any clk.

Test Plan:
1. Defaults, mode 0: WRITE frame 0x01, 0x12, 0xBEEF → exactly one reg_wr_en with reg_addr=0x12, reg_wdata=0xBEEF. start and frame_err stay 0.
2. START frame 0x02 followed by 24 zero bits → one start pulse within 2 clk of the 8th sample edge. No reg strobes occur.
3. READ frame 0x03, 0x05 with a bench model returning 0xA5C3 one clk after reg_rd_en → miso shifts 1010010111000011 over the DATA phase.
4. STATUS with npu_busy=1, npu_done=0 → DATA phase reads 0x0002. Then npu_done=1, busy=0 → reads 0x0001.
5. cs_n raised after 20 bits of a WRITE → frame_err pulses once and reg_wr_en is never asserted. A following full frame decodes correctly.
6. Repeat scenarios 1 and 3 with CPOL=1, CPHA=1 and with ADDR_W=4, DATA_W=32 → same decoded values. Also assert rst_n low mid-frame → all outputs 0 and FSM in IDLE.
